// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES/SNES pad poller.
// Holds the poll FSM state encoding, the default clock half-period for a
// 25.175 MHz pixel clock, the read widths for NES and SNES pads, and the
// NES button bit positions within a published button word.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  // About 6 us per half-period at 25.175 MHz
  localparam int unsigned HALF_25M  = 151;

  localparam int unsigned BITS_NES  = 8;
  localparam int unsigned BITS_SNES = 16;

  // NES button positions in the published word (bit 0 is shifted first)
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_channel.sv
// One pad's receive path: a 2-flop synchroniser on the serial data line, a
// BITS-wide shift/capture register and the published button word.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   pad_data    - raw serial data from the pad (active-low pressed, async)
//   en          - pad enabled for the current poll; disabled pads store 0
//   clear       - empty the capture register at poll start
//   sample      - capture one bit at position bit_idx
//   bit_idx     - bit position being captured
//   publish     - copy the completed capture (including this cycle's bit) to word
//   word        - registered, active-high button word
module nes_pad_channel
  import nes_pad_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned BCW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pad_data,
  input  logic            en,
  input  logic            clear,
  input  logic            sample,
  input  logic [BCW-1:0]  bit_idx,
  input  logic            publish,
  output logic [BITS-1:0] word
);

  logic [1:0]      sync_q;
  logic [BITS-1:0] sr;
  logic [BITS-1:0] sr_next_c;

  // Insert the synchronised, inverted data bit at the addressed position
  always_comb begin
    sr_next_c = sr;
    for (int k = 0; k < int'(BITS); k++) begin
      if (sample && (bit_idx == BCW'(k))) begin
        sr_next_c[k] = en & ~sync_q[1];
      end
    end
  end

  // Synchroniser, capture register and published word
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      sr     <= '0;
      word   <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_data};
      if (clear) begin
        sr <= '0;
      end else begin
        sr <= sr_next_c;
      end
      // Publishing from sr_next_c lets the final bit land in the same edge
      if (publish) begin
        word <= sr_next_c;
      end
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Serial poller for NUM_PADS NES/SNES controllers sharing one timing engine.
// A poll pulse latches every enabled pad, then shifts BITS bits out of each
// with BITS-1 clock pulses, and publishes all words together with a
// one-cycle valid strobe.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   poll        - start request (one-cycle pulse), ignored while busy
//   pad_en      - per-pad enable mask, captured when poll is accepted
//   pad_data    - serial data per pad, active-low pressed, asynchronous
//   pad_latch   - latch per pad, active high
//   pad_clk     - shift clock per pad, idles high
//   buttons     - pad p bit k at [p*BITS+k], 1 = pressed
//   valid       - one-cycle pulse when buttons updates
//   busy        - high from poll acceptance through the valid cycle
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = 2,
  parameter int unsigned BITS     = BITS_NES,
  parameter int unsigned HALF     = HALF_25M
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     poll,
  input  logic [NUM_PADS-1:0]      pad_en,
  input  logic [NUM_PADS-1:0]      pad_data,
  output logic [NUM_PADS-1:0]      pad_latch,
  output logic [NUM_PADS-1:0]      pad_clk,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic                     valid,
  output logic                     busy
);

  localparam int unsigned PW  = $clog2(2 * HALF);
  localparam int unsigned BCW = $clog2(BITS) + 1;

  state_t              state;
  logic [PW-1:0]       phase;
  logic [BCW-1:0]      bit_cnt;
  logic [NUM_PADS-1:0] en_q;

  logic phase_last_c;
  logic sample_c;
  logic last_bit_c;
  logic publish_c;
  logic clear_c;

  // Phase terminal count, sampling strobe and publish strobe
  always_comb begin
    phase_last_c = 1'b0;
    if (state == LATCH) begin
      phase_last_c = (phase == PW'(2 * HALF - 1));
    end else begin
      phase_last_c = (phase == PW'(HALF - 1));
    end
    sample_c   = phase_last_c && ((state == LATCH) || (state == CLK_HI));
    last_bit_c = (bit_cnt == BCW'(BITS - 1));
    publish_c  = sample_c && last_bit_c;
    clear_c    = (state == IDLE) && poll;
  end

  // Poll sequencer with registered pad and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      en_q      <= '0;
      pad_latch <= '0;
      pad_clk   <= '1;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (poll) begin
            en_q      <= pad_en;
            pad_latch <= pad_en;
            busy      <= 1'b1;
            phase     <= '0;
            bit_cnt   <= '0;
            state     <= LATCH;
          end
        end
        LATCH, CLK_HI: begin
          if (phase_last_c) begin
            phase     <= '0;
            pad_latch <= '0;
            if (last_bit_c) begin
              valid <= 1'b1;
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
              pad_clk <= ~en_q;
              state   <= CLK_LO;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        CLK_LO: begin
          if (phase_last_c) begin
            phase   <= '0;
            pad_clk <= '1;
            state   <= CLK_HI;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One receive channel per pad
  for (genvar p = 0; p < int'(NUM_PADS); p++) begin : g_chan
    nes_pad_channel #(
      .BITS (BITS),
      .BCW  (BCW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pad_data (pad_data[p]),
      .en       (en_q[p]),
      .clear    (clear_c),
      .sample   (sample_c),
      .bit_idx  (bit_cnt),
      .publish  (publish_c),
      .word     (buttons[p*BITS +: BITS])
    );
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: an 8-bit two-pad instance and a 16-bit one-pad
// instance share a pad model that behaves like a parallel-in shift register
// (latch reloads, each rising pad clock advances one button).
module tb_nes_pad_reader;

  localparam int H     = 4;
  localparam int EXP8  = 1 + 2 * H * 8;
  localparam int EXP16 = 1 + 2 * H * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, poll8, poll16;
  logic [1:0]  en8;
  logic [0:0]  en16;
  wire  [1:0]  data8;
  wire  [0:0]  data16;
  logic [1:0]  latch8, pclk8;
  logic [0:0]  latch16, pclk16;
  logic [15:0] btn8, btn16;
  logic        valid8, busy8, valid16, busy16;

  logic        noise_on;
  logic [2:0]  force_low;
  logic [15:0] press [3];

  int n_cmp = 0;
  int n_bad = 0;

  nes_pad_reader #(.NUM_PADS(2), .BITS(8), .HALF(H)) dut8 (
    .clk(clk), .reset(reset), .poll(poll8), .pad_en(en8), .pad_data(data8),
    .pad_latch(latch8), .pad_clk(pclk8), .buttons(btn8), .valid(valid8), .busy(busy8)
  );

  nes_pad_reader #(.NUM_PADS(1), .BITS(16), .HALF(H)) dut16 (
    .clk(clk), .reset(reset), .poll(poll16), .pad_en(en16), .pad_data(data16),
    .pad_latch(latch16), .pad_clk(pclk16), .buttons(btn16), .valid(valid16), .busy(busy16)
  );

  wire [2:0] lat_all = {latch16, latch8};
  wire [2:0] clk_all = {pclk16, pclk8};
  wire [2:0] data_all;
  assign data8  = data_all[1:0];
  assign data16 = data_all[2:2];

  // Line level for button i of pad p: low when pressed, high past the end
  function automatic logic lvl(input int p, input int i);
    logic [3:0] ii;
    if (i >= 0 && i < 16) begin
      ii = i[3:0];
      return ~press[p][ii];
    end
    return 1'b1;
  endfunction

  // Pad model with optional asynchronous chatter right after each edge
  for (genvar p = 0; p < 3; p++) begin : g_pad
    int   idx = 99;
    logic d   = 1'b1;
    assign data_all[p] = force_low[p] ? 1'b0 : d;
    always @(posedge lat_all[p] or posedge clk_all[p]) begin
      if (lat_all[p]) idx = 0;
      else            idx = idx + 1;
      if (noise_on) begin
        for (int i = 0; i < 3; i++) begin
          d = 1'($urandom);
          #3;
        end
      end
      d = lvl(p, idx);
    end
  end

  function automatic logic [15:0] exp_btn8(input logic [1:0] en);
    return {en[1] ? press[1][7:0] : 8'h00, en[0] ? press[0][7:0] : 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int          v1, v2, vc, lf, ll, pl0, pl1, dis_bad, busy_bad;
  logic [7:0]  rsnap;
  logic [15:0] rbtn;

  // Issue one poll and observe `limit` cycles; xa/xb inject extra polls,
  // rr asserts reset for one cycle at that relative cycle
  task automatic watch(input int which, input logic [1:0] en, input int limit,
                       input int xa, input int xb, input int rr);
    int         base = (which == 1) ? 2 : 0;
    int         np   = (which == 1) ? 1 : 2;
    int         ev   = (which == 1) ? EXP16 : EXP8;
    logic [2:0] prev_clk = 3'b111;
    logic       vsig, bsig;
    v1 = -1; v2 = -1; vc = 0; lf = -1; ll = -1; pl0 = 0; pl1 = 0;
    dis_bad = 0; busy_bad = 0; rsnap = 8'hff; rbtn = 16'hffff;
    @(negedge clk);
    en8  = en;
    en16 = en[0:0];
    if (which == 1) poll16 = 1'b1;
    else            poll8  = 1'b1;
    for (int rel = 1; rel <= limit; rel++) begin
      @(negedge clk);
      vsig = (which == 1) ? valid16 : valid8;
      bsig = (which == 1) ? busy16 : busy8;
      if (vsig) begin
        vc++;
        if (v1 < 0)      v1 = rel;
        else if (v2 < 0) v2 = rel;
      end
      if (lat_all[base]) begin
        if (lf < 0) lf = rel;
        ll = rel;
      end
      for (int k = 0; k < np; k++) begin
        if (prev_clk[base+k] && !clk_all[base+k]) begin
          if (k == 0) pl0++;
          else        pl1++;
        end
        if (!en[k] && (lat_all[base+k] || !clk_all[base+k])) dis_bad++;
      end
      prev_clk = clk_all;
      if (xa < 0 && xb < 0 && rr < 0 && (bsig !== (rel <= ev))) busy_bad++;
      if (rel == rr + 1) begin
        rsnap = {2'b00, latch8, pclk8, busy8, valid8};
        rbtn  = btn8;
      end
      poll8  = 1'b0;
      poll16 = 1'b0;
      if (rel == xa || rel == xb) begin
        if (which == 1) poll16 = 1'b1;
        else            poll8  = 1'b1;
      end
      reset = (rel == rr);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] en_r;
    reset = 1'b1; poll8 = 1'b0; poll16 = 1'b0; en8 = '0; en16 = '0;
    noise_on = 1'b0; force_low = '0;
    for (int i = 0; i < 3; i++) press[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_latch8", 32'(latch8), 32'(0));
    chk("rst_clk8",   32'(pclk8),  32'(3));
    chk("rst_btn8",   32'(btn8),   32'(0));
    chk("rst_valid8", 32'(valid8), 32'(0));
    chk("rst_busy8",  32'(busy8),  32'(0));
    chk("rst_clk16",  32'(pclk16), 32'(1));
    reset = 1'b0;
    @(negedge clk);

    // NES read: pad 0 A+START, pad 1 released
    press[0] = 16'h0009; press[1] = 16'h0000;
    watch(0, 2'b11, 70, -1, -1, -1);
    chk("nes_valid_at",  32'(v1),  32'(EXP8));
    chk("nes_valid_cnt", 32'(vc),  32'(1));
    chk("nes_latch_lo",  32'(lf),  32'(1));
    chk("nes_latch_hi",  32'(ll),  32'(2 * H));
    chk("nes_pulses0",   32'(pl0), 32'(7));
    chk("nes_pulses1",   32'(pl1), 32'(7));
    chk("nes_busy",      32'(busy_bad), 32'(0));
    chk("nes_buttons",   32'(btn8), 32'(exp_btn8(2'b11)));

    // Pad 1 disabled while its line is held low
    force_low = 3'b010;
    watch(0, 2'b01, 70, -1, -1, -1);
    chk("dis_buttons", 32'(btn8),    32'(exp_btn8(2'b01)));
    chk("dis_idle",    32'(dis_bad), 32'(0));
    chk("dis_pulses1", 32'(pl1),     32'(0));
    chk("dis_pulses0", 32'(pl0),     32'(7));
    force_low = '0;

    // SNES read: bits 0 and 11 pressed
    press[2] = 16'h0801;
    watch(1, 2'b01, EXP16 + 5, -1, -1, -1);
    chk("snes_valid_at", 32'(v1),    32'(EXP16));
    chk("snes_pulses",   32'(pl0),   32'(15));
    chk("snes_busy",     32'(busy_bad), 32'(0));
    chk("snes_buttons",  32'(btn16), 32'(press[2]));

    // Poll while busy is ignored; poll right after valid is accepted
    watch(0, 2'b11, 140, 20, EXP8 + 1, -1);
    chk("b2b_first",   32'(v1), 32'(EXP8));
    chk("b2b_second",  32'(v2), 32'(EXP8 + 1 + EXP8));
    chk("b2b_count",   32'(vc), 32'(2));
    chk("b2b_buttons", 32'(btn8), 32'(exp_btn8(2'b11)));

    // Reset mid-shift aborts without publishing
    watch(0, 2'b11, 80, -1, -1, 30);
    chk("abort_outputs", 32'(rsnap), 32'(8'h0C));
    chk("abort_buttons", 32'(rbtn),  32'(0));
    chk("abort_valid",   32'(vc),    32'(0));
    chk("abort_hold",    32'(btn8),  32'(0));

    // Random buttons and enables with chatter on the data lines
    noise_on = 1'b1;
    for (int it = 0; it < 4; it++) begin
      press[0] = 16'($urandom_range(0, 255));
      press[1] = 16'($urandom_range(0, 255));
      en_r     = 2'($urandom_range(0, 3));
      watch(0, en_r, 70, -1, -1, -1);
      chk("rnd8_valid_at", 32'(v1),   32'(EXP8));
      chk("rnd8_buttons",  32'(btn8), 32'(exp_btn8(en_r)));
    end
    for (int it = 0; it < 2; it++) begin
      press[2] = 16'($urandom);
      watch(1, 2'b01, EXP16 + 5, -1, -1, -1);
      chk("rnd16_valid_at", 32'(v1),    32'(EXP16));
      chk("rnd16_buttons",  32'(btn16), 32'(press[2]));
    end
    noise_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
